fetch_queue: RTL



---
 rtl/fetch_queue_if.sv | 26 ++
 rtl/fetch_queue.sv | 100 ++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue signal bundle: instruction-memory request/response, PC-select
// control and the decode-side valid/ready handshake.
interface fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic [31:0] out_pcp4;
    logic [2:0]  count;

    modport master (
        output imem_req, imem_addr, out_valid, out_ins, out_pc, out_pcp4, count,
        input  imem_rdata, redirect, redirect_pc, halt, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_ins, out_pc, out_pcp4, count,
        output imem_rdata, redirect, redirect_pc, halt, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: drives a 1-cycle imem, buffers returned words
// with their PC in a small FIFO, and flushes/restarts on redirect.
module fetch_queue #(
    parameter int          DEPTH = 2,
    parameter logic [31:0] ENTRY = 32'h0040_0000
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master fq
);
    localparam int PW = (DEPTH > 2) ? 2 : 1;

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d, ipc_q;
    logic          inflight_q;
    logic [2:0]    count_q, count_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [31:0]   ins_mem [DEPTH];
    logic [31:0]   pc_mem  [DEPTH];
    logic          req, pop, push, nonempty, valid;
    int            occ;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (fq.halt && !fq.redirect) state_d = HALT;
            HALT:    if (fq.redirect || !fq.halt) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Occupancy counts the outstanding response so a full FIFO never overflows.
    always_comb begin
        occ = int'(count_q) + int'(inflight_q) - int'(pop);
        req = (state_q == RUN) && !fq.halt && !fq.redirect && (occ < DEPTH);
    end

    always_comb begin
        nonempty = (count_q != 3'd0);
        valid    = nonempty && !fq.redirect;
        pop      = valid && fq.out_ready;
        push     = inflight_q && !fq.redirect;
        pc_d     = pc_q;
        count_d  = count_q + {2'b0, push} - {2'b0, pop};
        head_d   = pop  ? inc(head_q) : head_q;
        tail_d   = push ? inc(tail_q) : tail_q;
        if (req) pc_d = pc_q + 32'd4;
        if (fq.redirect) begin
            pc_d    = fq.redirect_pc & ~32'h3;
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= ENTRY;
            ipc_q      <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= req;
            if (req) ipc_q <= pc_q;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem[tail_q] <= fq.imem_rdata;
            pc_mem[tail_q]  <= ipc_q;
        end
    end

    assign fq.imem_req  = req;
    assign fq.imem_addr = pc_q;
    assign fq.out_valid = valid;
    assign fq.out_ins   = nonempty ? ins_mem[head_q] : 32'd0;
    assign fq.out_pc    = nonempty ? pc_mem[head_q] : 32'd0;
    assign fq.out_pcp4  = nonempty ? pc_mem[head_q] + 32'd4 : 32'd0;
    assign fq.count     = count_q;
endmodule
